key_debounce_pulse: RTL and testbench

- Cleans the raw push-button inputs (left/right gesture keys, plus any others) before they reach the gesture power FSM and the mode logic.
- Per key: 2-FF synchronizer, then a debounce state machine, then single-cycle press/release pulses. Optional long-press pulse.
- The gesture power controller consumes key_press bits as its left_key/right_key inputs.

---
 rtl/key_debounce_pulse.sv | 179 +++++++++++++++++
 tb/tb_key_debounce_pulse.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: per key a 2-FF synchronizer, a debounce FSM and one-cycle press/release pulses.
// Latency: a stable level change is accepted and pulsed 2 + DEBOUNCE_CYCLES cycles after the raw edge is first sampled.
// Backpressure: none; pulses are fire-and-forget, one cycle wide, and consumers must sample them every cycle.
//
// Ports:
//   clk         - system clock
//   reset       - asynchronous active-low reset
//   key_raw     - raw asynchronous button pins, one bit per key (bit 0 = left, bit 1 = right)
//   key_level   - debounced level, 1 = pressed
//   key_press   - one-cycle pulse when a press is accepted
//   key_release - one-cycle pulse when a release is accepted
//   key_long    - one-cycle pulse after a key has been held HOLD_CYCLES cycles
//
// Optional feature: define KEY_LONG_PRESS_EN to build the per-key hold counters that drive key_long.
// Without it, key_long is tied to 0 and HOLD_CYCLES is ignored.
module key_debounce_pulse #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int HOLD_CYCLES     = 200000000,
    parameter bit ACTIVE_LEVEL    = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int            CW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    // With a one-sample debounce the very first sample already completes the window.
    localparam bit            ACCEPT_NOW = (DEBOUNCE_CYCLES == 1);

    // Encoding chosen so bit 1 is exactly the debounced level (DOWN and CONFIRM_UP).
    localparam logic [1:0] ST_UP         = 2'b00;
    localparam logic [1:0] ST_CONFIRM_DN = 2'b01;
    localparam logic [1:0] ST_DOWN       = 2'b10;
    localparam logic [1:0] ST_CONFIRM_UP = 2'b11;

`ifdef KEY_LONG_PRESS_EN
    localparam int            HW       = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
`endif

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] pressed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= {NUM_KEYS{~ACTIVE_LEVEL}};
            sync2_q <= {NUM_KEYS{~ACTIVE_LEVEL}};
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    // Normalise polarity so the FSM only ever sees 1 = pressed.
    assign pressed = ~(sync2_q ^ {NUM_KEYS{ACTIVE_LEVEL}});

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic [1:0]    state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          press_q, press_d;
        logic          release_q, release_d;

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                ST_UP: begin
                    if (pressed[k]) begin
                        if (ACCEPT_NOW) begin
                            state_d = ST_DOWN;
                            press_d = 1'b1;
                        end else begin
                            state_d = ST_CONFIRM_DN;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_CONFIRM_DN: begin
                    if (!pressed[k]) begin
                        state_d = ST_UP;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_DOWN;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DOWN: begin
                    if (!pressed[k]) begin
                        if (ACCEPT_NOW) begin
                            state_d   = ST_UP;
                            release_d = 1'b1;
                        end else begin
                            state_d = ST_CONFIRM_UP;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                default: begin // ST_CONFIRM_UP
                    if (pressed[k]) begin
                        state_d = ST_DOWN;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = ST_UP;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q   <= ST_UP;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign key_level[k]   = state_q[1];
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;

`ifdef KEY_LONG_PRESS_EN
        logic [HW-1:0] hold_q, hold_d;
        logic          long_q, long_d;

        // Cleared on entry to DOWN from the press side and on any return to UP;
        // a bounce back from CONFIRM_UP keeps the accumulated hold time.
        always_comb begin
            hold_d = hold_q;
            long_d = 1'b0;
            if (state_d == ST_UP || (state_d == ST_DOWN && !state_q[1])) begin
                hold_d = '0;
            end else if (state_q[1] && hold_q != HOLD_MAX) begin
                hold_d = hold_q + HOLD_ONE;
                long_d = (hold_q == HOLD_PRE);
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else begin
                hold_q <= hold_d;
                long_q <= long_d;
            end
        end

        assign key_long[k] = long_q;
`else
        assign key_long[k] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_debounce_pulse.sv
module tb_key_debounce_pulse;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] key_raw;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [1:0] key_long;

    int n_vec = 0;
    int n_err = 0;

`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    key_debounce_pulse #(
        .NUM_KEYS        (2),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (10),
        .ACTIVE_LEVEL    (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Inputs were just changed after an edge; expect the given pulses exactly lat edges later.
    task automatic watch(input string tag, input int lat, input logic [1:0] ep, input logic [1:0] er);
        for (int i = 1; i <= lat + 1; i++) begin
            tick(1);
            check_val({tag, "_press"}, key_press,   (i == lat) ? ep : 2'b00);
            check_val({tag, "_rel"},   key_release, (i == lat) ? er : 2'b00);
        end
    endtask

    initial begin
        reset   = 1'b0;
        key_raw = 2'b11;
        tick(5);
        check_val("rst_level",   key_level,   2'b00);
        check_val("rst_press",   key_press,   2'b00);
        check_val("rst_release", key_release, 2'b00);
        check_val("rst_long",    key_long,    2'b00);

        // Keys held through reset release: press pulse on the 6th edge.
        reset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            check_val("post_rst_press", key_press, (i == 6) ? 2'b11 : 2'b00);
        end
        check_val("post_rst_level", key_level, 2'b11);

        key_raw = 2'b00;
        watch("rel_both", 6, 2'b00, 2'b11);
        check_val("rel_both_level", key_level, 2'b00);

        // Clean press/release on key 0.
        key_raw = 2'b01;
        watch("press0", 6, 2'b01, 2'b00);
        check_val("press0_level", key_level, 2'b01);
        key_raw = 2'b00;
        watch("rel0", 6, 2'b00, 2'b01);
        check_val("rel0_level", key_level, 2'b00);

        // Bounce 1,1,1,0 never fills the 4-sample window.
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 4; j++) begin
                key_raw = {1'b0, (j != 3)};
                tick(1);
                check_val("bounce_press", key_press,   2'b00);
                check_val("bounce_rel",   key_release, 2'b00);
                check_val("bounce_level", key_level,   2'b00);
            end
        end
        key_raw = 2'b00;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check_val("bounce_tail_press", key_press, 2'b00);
            check_val("bounce_tail_level", key_level, 2'b00);
        end

        // Short release glitch while DOWN is rejected.
        key_raw = 2'b01;
        watch("press0b", 6, 2'b01, 2'b00);
        key_raw = 2'b00;
        tick(2);
        key_raw = 2'b01;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check_val("glitch_rel",   key_release, 2'b00);
            check_val("glitch_level", key_level,   2'b01);
        end
        key_raw = 2'b00;
        watch("rel0b", 6, 2'b00, 2'b01);

        // Staggered keys: key 1 raised two edges after key 0.
        key_raw = 2'b01;
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            check_val("stagger_press", key_press,
                      (i == 6) ? 2'b01 : ((i == 8) ? 2'b10 : 2'b00));
            if (i == 2) key_raw = 2'b11;
        end
        check_val("stagger_level", key_level, 2'b11);
        key_raw = 2'b00;
        watch("stagger_rel", 6, 2'b00, 2'b11);
        key_raw = 2'b11;
        watch("both_press", 6, 2'b11, 2'b00);
        key_raw = 2'b00;
        watch("both_rel", 6, 2'b00, 2'b11);

        // Reset after three accepted samples on key 1 discards the pending press.
        key_raw = 2'b10;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            check_val("pre_rst_press", key_press, 2'b00);
        end
        reset = 1'b0;
        #1;
        check_val("mid_rst_press", key_press, 2'b00);
        check_val("mid_rst_level", key_level, 2'b00);
        tick(1);
        check_val("mid_rst_press2", key_press, 2'b00);
        reset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            check_val("after_rst_press", key_press, (i == 6) ? 2'b10 : 2'b00);
        end
        check_val("after_rst_level", key_level, 2'b10);
        key_raw = 2'b00;
        watch("rel1", 6, 2'b00, 2'b10);

        // Long hold on key 0: key_long 10 cycles after the press pulse, once.
        key_raw = 2'b01;
        for (int i = 1; i <= 37; i++) begin
            tick(1);
            check_val("long_press", key_press, (i == 6) ? 2'b01 : 2'b00);
            check_val("long_pulse", key_long, (LONG_EN && i == 16) ? 2'b01 : 2'b00);
        end
        key_raw = 2'b00;
        watch("long_rel", 6, 2'b00, 2'b01);
        check_val("final_level", key_level, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
